clk_monitor: RTL and testbench

Frequency/lock monitor for the system clock domain, the consumer end of the clock controller. It samples a slow asynchronous reference signal (`ref_in`), counts its rising edges over a fixed window of `clk` cycles, and checks each count against a min/max band. It asserts `locked` after a run of consecutive in-band windows, drops it on the first out-of-band window, and keeps a sticky fault flag for software and reset sequencing.

---
 rtl/clk_monitor.sv | 125 ++++++++++++
 tb/tb_clk_monitor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/clk_monitor.sv
// Reference-clock frequency/lock monitor: counts synchronized rising edges of
// ref_in per WINDOW clk cycles and tracks lock against a [CNT_MIN, CNT_MAX] band.
module clk_monitor #(
  parameter int unsigned WINDOW       = 1024,
  parameter int unsigned CW           = 16,
  parameter int unsigned CNT_MIN      = 120,
  parameter int unsigned CNT_MAX      = 136,
  parameter int unsigned GOOD_WINDOWS = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ref_in,
  input  logic          fault_clr,
  output logic          locked,
  output logic          fault,
  output logic [CW-1:0] last_count,
  output logic          count_valid
);

  localparam int unsigned WW = $clog2(WINDOW);
  localparam int unsigned RW = $clog2(GOOD_WINDOWS + 1);
  localparam int unsigned XW = (CW > 32) ? CW : 32;
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(GOOD_WINDOWS);

  typedef enum logic {
    ST_UNLOCKED,
    ST_LOCKED
  } state_e;

  logic          sync1_q, sync2_q, prev_q;
  logic [WW-1:0] win_q, win_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_fin;
  logic [CW-1:0] last_q, last_d;
  logic          cv_q, cv_d;
  state_e        state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic          fault_q, fault_d;
  logic          edge_det, terminal, good, fault_set;

  assign edge_det = sync2_q & ~prev_q;
  assign terminal = (win_q == WIN_LAST);

  // Count as it stands after this cycle's edge; this is what gets evaluated on the terminal cycle.
  assign cnt_fin = (edge_det && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
  assign good    = (XW'(cnt_fin) >= XW'(CNT_MIN)) && (XW'(cnt_fin) <= XW'(CNT_MAX));

  always_comb begin
    win_d  = terminal ? '0 : win_q + 1'b1;
    cnt_d  = terminal ? '0 : cnt_fin;
    last_d = terminal ? cnt_fin : last_q;
    cv_d   = terminal;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      win_q   <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      cv_q    <= 1'b0;
    end else begin
      sync1_q <= ref_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      cv_q    <= cv_d;
    end
  end

  // Lock FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_UNLOCKED;
      run_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      fault_q <= fault_d;
    end
  end

  // Lock FSM: next state
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    fault_set = 1'b0;
    if (terminal) begin
      case (state_q)
        ST_UNLOCKED: begin
          if (good) begin
            if (run_q != RUN_MAX) run_d = run_q + 1'b1;
            if (run_d == RUN_MAX) state_d = ST_LOCKED;
          end else begin
            run_d = '0;
          end
        end
        ST_LOCKED: begin
          if (!good) begin
            run_d     = '0;
            state_d   = ST_UNLOCKED;
            fault_set = 1'b1;
          end
        end
      endcase
    end
    // A set in the same cycle as a clear request takes priority.
    fault_d = fault_set | (fault_q & ~fault_clr);
  end

  // Lock FSM: outputs
  always_comb begin
    locked = (state_q == ST_LOCKED);
    fault  = fault_q;
  end

  assign last_count  = last_q;
  assign count_valid = cv_q;

endmodule

// File: tb/tb_clk_monitor.sv
// Bench for clk_monitor: a default instance and a CW=4/WINDOW=64 instance share
// stimulus; a window-level behavioural model predicts every output every cycle.
module tb_clk_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ref_in = 1'b0;
  logic        fault_clr = 1'b0;
  logic        locked0, fault0, cv0;
  logic [15:0] last0;
  logic        locked1, fault1, cv1;
  logic [3:0]  last1;

  always #5 clk = ~clk;

  clk_monitor u_dut (
    .clk(clk), .reset(reset), .ref_in(ref_in), .fault_clr(fault_clr),
    .locked(locked0), .fault(fault0), .last_count(last0), .count_valid(cv0)
  );

  clk_monitor #(.WINDOW(64), .CW(4)) u_sat (
    .clk(clk), .reset(reset), .ref_in(ref_in), .fault_clr(fault_clr),
    .locked(locked1), .fault(fault1), .last_count(last1), .count_valid(cv1)
  );

  // Model: windows of win_len cycles; an edge of ref_in is seen 2 samples late,
  // counts saturate, locked == (run of good windows >= 4), fault on lock loss.
  int win_len[2] = '{1024, 64};
  int cmax[2]    = '{65535, 15};
  bit hist[$];
  int m_pos[2], m_cnt[2], m_streak[2], m_last[2];
  bit m_locked[2], m_fault[2], m_cv[2];

  int n_pass = 0, n_checks = 0, n_fail = 0;
  int since_rel = 0, first_lock = -1;
  int acc = 0, hi_left = 0;

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, inst, obs, exp);
    end
  endtask

  function automatic void model_edge(input bit r, input bit fc, input bit rs);
    bit rise, good, was, set;
    if (rs) begin
      hist.delete();
      repeat (3) hist.push_back(1'b0);
      for (int i = 0; i < 2; i++) begin
        m_pos[i] = 0; m_cnt[i] = 0; m_streak[i] = 0; m_last[i] = 0;
        m_locked[i] = 0; m_fault[i] = 0; m_cv[i] = 0;
      end
      return;
    end
    hist.push_back(r);
    if (hist.size() > 4) void'(hist.pop_front());
    rise = hist[1] && !hist[0];
    for (int i = 0; i < 2; i++) begin
      if (rise && m_cnt[i] < cmax[i]) m_cnt[i]++;
      m_cv[i] = 0;
      set = 0;
      if (m_pos[i] == win_len[i] - 1) begin
        m_last[i]   = m_cnt[i];
        m_cv[i]     = 1;
        good        = (m_cnt[i] >= 120) && (m_cnt[i] <= 136);
        was         = m_streak[i] >= 4;
        m_streak[i] = good ? m_streak[i] + 1 : 0;
        m_locked[i] = m_streak[i] >= 4;
        set         = was && !m_locked[i];
        m_cnt[i]    = 0;
        m_pos[i]    = 0;
      end else begin
        m_pos[i]++;
      end
      if (set) m_fault[i] = 1;
      else if (fc) m_fault[i] = 0;
    end
  endfunction

  task automatic tick(input bit r, input bit fc, input bit rs);
    ref_in = r; fault_clr = fc; reset = rs;
    @(posedge clk);
    model_edge(r, fc, rs);
    since_rel = rs ? 0 : since_rel + 1;
    #1;
    if (rs) first_lock = -1;
    else if (first_lock < 0 && locked0 === 1'b1) first_lock = since_rel;
    chk("locked", 0, locked0, m_locked[0]);
    chk("fault", 0, fault0, m_fault[0]);
    chk("count_valid", 0, cv0, m_cv[0]);
    chk("last_count", 0, last0, m_last[0]);
    chk("locked", 1, locked1, m_locked[1]);
    chk("fault", 1, fault1, m_fault[1]);
    chk("count_valid", 1, cv1, m_cv[1]);
    chk("last_count", 1, last1, m_last[1]);
  endtask

  // Pulse generator: 'rate' pulses per 1024 cycles, evenly spread, width 1..3 when width==0.
  task automatic gen(input int n, input int rate, input int width, input bit fc_first);
    for (int i = 0; i < n; i++) begin
      acc += rate;
      if (acc >= 1024) begin
        acc -= 1024;
        hi_left = (width == 0) ? int'($urandom_range(3, 1)) : width;
      end
      tick(hi_left > 0, fc_first && i == 0, 1'b0);
      if (hi_left > 0) hi_left--;
    end
  endtask

  task automatic do_reset();
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    acc = int'($urandom_range(1023, 0));
    hi_left = 0;
  endtask

  initial begin
    int seen;

    // Reset state and lock at clk/8
    do_reset();
    chk("rst_last", 0, last0, 0);
    chk("rst_locked", 0, locked0, 0);
    gen(5 * 1024, 128, 0, 1'b0);
    chk("lock_cycle", 0, first_lock + 1, 4097);
    chk("lock_held", 0, locked0, 1);

    // Drop to clk/16: lock lost, fault sticky until cleared, relock after 4 windows
    gen(1024, 64, 0, 1'b0);
    chk("drop_locked", 0, locked0, 0);
    chk("drop_fault", 0, fault0, 1);
    gen(2048, 128, 0, 1'b0);
    chk("fault_sticky", 0, fault0, 1);
    chk("relock_early", 0, locked0, 0);
    gen(2048, 128, 0, 1'b1);
    chk("relock", 0, locked0, 1);
    chk("fault_cleared", 0, fault0, 0);

    // Band edges from reset
    do_reset(); gen(6 * 1024, 120, 0, 1'b0);
    chk("band_120", 0, locked0, 1);
    do_reset(); gen(6 * 1024, 136, 0, 1'b0);
    chk("band_136", 0, locked0, 1);
    do_reset(); gen(6 * 1024, 119, 0, 1'b0);
    chk("band_119", 0, locked0, 0);
    do_reset(); gen(6 * 1024, 137, 0, 1'b0);
    chk("band_137", 0, locked0, 0);
    chk("band_fault", 0, fault0, 0);

    // 3 good, 1 bad, 4 good
    do_reset();
    gen(3 * 1024, 128, 0, 1'b0);
    gen(1024, 64, 0, 1'b0);
    gen(3 * 1024, 128, 0, 1'b0);
    chk("run_restart", 0, locked0, 0);
    gen(1024, 128, 0, 1'b0);
    chk("run_lock", 0, locked0, 1);
    chk("run_fault", 0, fault0, 0);

    // Stuck high while locked; clear requested on the very edge that sets fault
    for (int i = 0; i < 1024; i++) tick(1'b1, m_locked[0] && m_pos[0] == 1023, 1'b0);
    chk("stuck_locked", 0, locked0, 0);
    chk("set_wins", 0, fault0, 1);
    for (int i = 0; i < 1024; i++) tick(1'b1, 1'b0, 1'b0);
    chk("stuck_count", 0, last0, 0);
    tick(1'b1, 1'b1, 1'b0);
    chk("clr_after", 0, fault0, 0);

    // Saturation in the narrow instance, then reset at win == 30
    do_reset();
    gen(4 * 64, 256, 2, 1'b0);
    chk("sat_count", 1, last1, 15);
    gen(30, 256, 2, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    chk("midrst_last", 1, last1, 0);
    chk("midrst_cv", 1, cv1, 0);
    seen = -1;
    for (int i = 1; i <= 200 && seen < 0; i++) begin
      gen(1, 256, 2, 1'b0);
      if (cv1 === 1'b1) seen = i;
    end
    chk("full_window", 1, seen, 64);
    chk("post_rst_count", 1, last1, 15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
